// File: rtl/eth_tx_fifo_reader.sv
// eth_tx_fifo_reader
// Reads one Ethernet frame out of a byte FIFO and serialises it onto an RMII
// transmit interface: 7 preamble bytes, SFD, payload, zero pad up to MIN_BYTES,
// then the 4-byte CRC-32 FCS, followed by an inter-frame gap.
//
// Ports
//   Clk         RMII 50 MHz reference clock, all logic on the rising edge
//   Rst         synchronous active-high reset
//   Tx_Start    single-cycle frame request, honoured only while idle
//   Byte_Count  frame length in FIFO bytes, captured with an accepted Tx_Start
//   q           FIFO read data, valid the clock after Rd_En
//   empty       FIFO empty flag
//   Rd_En       FIFO pop request, one clock per byte
//   Tx_En       RMII transmit enable
//   Txd         RMII transmit dibit, bit 0 of each byte first
//   Busy        high whenever a frame or its gap is in progress
//   Done        one-clock pulse when a frame completes normally
//   Underrun    one-clock pulse when a frame is aborted on an empty FIFO
module eth_tx_fifo_reader #(
    parameter int unsigned MIN_BYTES  = 60,
    parameter int unsigned IFG_CYCLES = 48
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Tx_Start,
    input  logic [10:0] Byte_Count,
    input  logic [7:0]  q,
    input  logic        empty,
    output logic        Rd_En,
    output logic        Tx_En,
    output logic [1:0]  Txd,
    output logic        Busy,
    output logic        Done,
    output logic        Underrun
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PAD      = 3'd4;
    localparam logic [2:0] ST_FCS      = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;

    localparam int unsigned        GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(IFG_CYCLES - 1);
    localparam logic [11:0]        MIN_LEN  = 12'(MIN_BYTES);

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [10:0]      byte_cnt_q, byte_cnt_d;
    logic [10:0]      pop_cnt_q, pop_cnt_d;
    logic [10:0]      len_q, len_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [31:0]      crc_q, crc_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             abort_q, abort_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic             need_pop;
    logic             starve;
    logic [11:0]      byte_nxt;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q + 2'd1;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        shreg_d    = shreg_q >> 2;
        crc_d      = crc_q;
        gap_cnt_d  = gap_cnt_q;
        abort_d    = abort_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        byte_nxt = {1'b0, byte_cnt_q} + 12'd1;

        // The pop for the next payload byte is issued two dibits early so q is
        // ready when the current byte finishes shifting out.
        need_pop = ((state_q == ST_SFD) || (state_q == ST_DATA)) && (idx_q == 2'd2) &&
                   (pop_cnt_q < len_q);
        starve   = need_pop && empty;
        Rd_En    = need_pop && !empty && !Rst;
        pop_cnt_d = Rd_En ? (pop_cnt_q + 11'd1) : pop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                idx_d   = 2'd0;
                shreg_d = '0;
                if (Tx_Start && (Byte_Count != 11'd0)) begin
                    state_d    = ST_PREAMBLE;
                    len_d      = Byte_Count;
                    byte_cnt_d = '0;
                    pop_cnt_d  = '0;
                    shreg_d    = 32'h55;
                    crc_d      = 32'hFFFF_FFFF;
                    abort_d    = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (idx_q == 2'd3) begin
                    if (byte_cnt_q == 11'd6) begin
                        state_d    = ST_SFD;
                        byte_cnt_d = '0;
                        shreg_d    = 32'hD5;
                    end else begin
                        byte_cnt_d = byte_nxt[10:0];
                        shreg_d    = 32'h55;
                    end
                end
            end
            ST_SFD, ST_DATA: begin
                if (starve) begin
                    state_d    = ST_IFG;
                    idx_d      = 2'd0;
                    gap_cnt_d  = '0;
                    abort_d    = 1'b1;
                    underrun_d = 1'b1;
                end else if (idx_q == 2'd3) begin
                    if ((state_q == ST_SFD) || (byte_nxt < {1'b0, len_q})) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = (state_q == ST_SFD) ? 11'd0 : byte_nxt[10:0];
                        shreg_d    = {24'h0, q};
                        crc_d      = crc_byte(crc_q, q);
                    end else if ({1'b0, len_q} < MIN_LEN) begin
                        // byte_cnt keeps counting frame bytes through the pad.
                        state_d    = ST_PAD;
                        byte_cnt_d = len_q;
                        shreg_d    = '0;
                        crc_d      = crc_byte(crc_q, 8'h00);
                    end else begin
                        state_d    = ST_FCS;
                        byte_cnt_d = '0;
                        shreg_d    = ~crc_q;
                    end
                end
            end
            ST_PAD: begin
                if (idx_q == 2'd3) begin
                    if (byte_nxt < MIN_LEN) begin
                        byte_cnt_d = byte_nxt[10:0];
                        shreg_d    = '0;
                        crc_d      = crc_byte(crc_q, 8'h00);
                    end else begin
                        state_d    = ST_FCS;
                        byte_cnt_d = '0;
                        shreg_d    = ~crc_q;
                    end
                end
            end
            ST_FCS: begin
                // All 32 FCS bits sit in shreg; it simply keeps shifting.
                if (idx_q == 2'd3) begin
                    if (byte_cnt_q == 11'd3) begin
                        state_d   = ST_IFG;
                        gap_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_nxt[10:0];
                    end
                end
            end
            ST_IFG: begin
                idx_d   = 2'd0;
                shreg_d = '0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = !abort_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            pop_cnt_q  <= '0;
            len_q      <= '0;
            shreg_q    <= '0;
            crc_q      <= 32'hFFFF_FFFF;
            gap_cnt_q  <= '0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            len_q      <= len_d;
            shreg_q    <= shreg_d;
            crc_q      <= crc_d;
            gap_cnt_q  <= gap_cnt_d;
            abort_q    <= abort_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign Tx_En    = (state_q == ST_PREAMBLE) || (state_q == ST_SFD) || (state_q == ST_DATA) ||
                      (state_q == ST_PAD) || (state_q == ST_FCS);
    assign Txd      = Tx_En ? shreg_q[1:0] : 2'b00;
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = done_q;
    assign Underrun = underrun_q;

endmodule

// File: tb/tb_eth_tx_fifo_reader.sv
// Bench for eth_tx_fifo_reader: a queue-based FIFO model feeds the DUT, and the
// expected wire stream is built byte-wise from the frame format (preamble, SFD,
// payload, zero pad, complemented CRC-32 LSB first).
module tb_eth_tx_fifo_reader;
    localparam int MIN_BYTES  = 60;
    localparam int IFG_CYCLES = 48;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Tx_Start = 1'b0;
    logic [10:0] Byte_Count = '0;
    logic [7:0]  q = '0;
    logic        empty = 1'b1;
    logic        Rd_En, Tx_En, Busy, Done, Underrun;
    logic [1:0]  Txd;

    eth_tx_fifo_reader #(
        .MIN_BYTES (MIN_BYTES),
        .IFG_CYCLES(IFG_CYCLES)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Tx_Start  (Tx_Start),
        .Byte_Count(Byte_Count),
        .q         (q),
        .empty     (empty),
        .Rd_En     (Rd_En),
        .Tx_En     (Tx_En),
        .Txd       (Txd),
        .Busy      (Busy),
        .Done      (Done),
        .Underrun  (Underrun)
    );

    always #10 Clk = ~Clk;

    logic [7:0] fifo[$];
    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    logic [1:0] cap[$];

    int checks = 0;
    int errors = 0;
    int bad_pops = 0;
    int n_rd, n_done, n_und, ten_cyc, txd_bad;
    int fall_cyc, done_cyc, und_cyc, busy_low_cyc;

    // FIFO model: registered read data, empty reflects the queue after any pop.
    always @(posedge Clk) begin
        if (Rd_En === 1'b1 && fifo.size() > 0) q <= fifo.pop_front();
        empty <= (fifo.size() == 0);
    end

    always @(negedge Clk) begin
        if (Rd_En === 1'b1 && (empty === 1'b1 || Rst === 1'b1)) bad_pops++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Frame bytes as they must appear on the wire.
    task automatic build_exp(input int len);
        logic [31:0] crc;
        int total;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(src[i]);
            crc = crc_upd(crc, src[i]);
        end
        for (total = len; total < MIN_BYTES; total++) begin
            exp_q.push_back(8'h00);
            crc = crc_upd(crc, 8'h00);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
    endtask

    function automatic int stream_errs(input int ndib);
        int e;
        logic [7:0] b;
        e = 0;
        for (int k = 0; k < ndib; k++) begin
            b = exp_q[k/4] >> (2 * (k % 4));
            if (k >= cap.size()) e++;
            else if (cap[k] !== b[1:0]) e++;
        end
        return e;
    endfunction

    task automatic load_fifo(input int n, input bit seq);
        logic [7:0] b;
        fifo.delete();
        src.delete();
        for (int i = 0; i < n; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            fifo.push_back(b);
            src.push_back(b);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        @(posedge Clk);
        #1;
        Tx_Start   = 1'b1;
        Byte_Count = 11'(len);
        @(posedge Clk);
        #1;
        Tx_Start   = 1'b0;
        Byte_Count = 11'($urandom);
    endtask

    // Cycle 0 is the first clock after Tx_Start was accepted.
    task automatic run_frame(input int max_cyc);
        bit seen;
        cap.delete();
        n_rd = 0; n_done = 0; n_und = 0; ten_cyc = 0; txd_bad = 0;
        fall_cyc = -1; done_cyc = -1; und_cyc = -1; busy_low_cyc = -1;
        seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge Clk);
            if (Rd_En === 1'b1) n_rd++;
            if (Tx_En === 1'b1) begin
                ten_cyc++;
                cap.push_back(Txd);
                seen = 1'b1;
            end else begin
                if (Txd !== 2'b00) txd_bad++;
                if (seen && fall_cyc < 0) fall_cyc = c;
            end
            if (Done === 1'b1) begin n_done++; done_cyc = c; end
            if (Underrun === 1'b1) begin n_und++; und_cyc = c; end
            if (Busy !== 1'b1) begin busy_low_cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Rd_En, Tx_En, Txd, Busy, Done, Underrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {Rd_En, Tx_En, Txd, Busy, Done, Underrun});
        end
        @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic test_basic_60();
        load_fifo(60, 1'b1);
        start_frame(60);
        run_frame(3000);
        build_exp(60);
        checks++;
        if (ten_cyc !== 288) begin errors++; $display("FAIL basic_tx_en_len: got %0d, expected 288", ten_cyc); end
        checks++;
        if (n_rd !== 60) begin errors++; $display("FAIL basic_rd_count: got %0d, expected 60", n_rd); end
        checks++;
        if (n_done !== 1 || done_cyc - fall_cyc !== IFG_CYCLES) begin
            errors++;
            $display("FAIL basic_done_delay: got %0d pulses at +%0d, expected 1 at +%0d",
                     n_done, done_cyc - fall_cyc, IFG_CYCLES);
        end
        checks++;
        if (stream_errs(exp_q.size() * 4) !== 0 || cap.size() !== exp_q.size() * 4) begin
            errors++;
            $display("FAIL basic_stream: got %0d bad of %0d dibits, expected 0 bad of %0d",
                     stream_errs(exp_q.size() * 4), cap.size(), exp_q.size() * 4);
        end
        checks++;
        if (txd_bad !== 0 || n_und !== 0) begin
            errors++;
            $display("FAIL basic_idle_txd: got txd_bad=%0d und=%0d, expected 0 0", txd_bad, n_und);
        end
    endtask

    task automatic test_pad_14();
        logic [31:0] r;
        logic [7:0]  b;
        load_fifo(14, 1'b0);
        start_frame(14);
        run_frame(3000);
        build_exp(14);
        checks++;
        if (n_rd !== 14) begin errors++; $display("FAIL pad_rd_count: got %0d, expected 14", n_rd); end
        checks++;
        if (ten_cyc !== 288) begin errors++; $display("FAIL pad_tx_en_len: got %0d, expected 288", ten_cyc); end
        checks++;
        if (stream_errs(exp_q.size() * 4) !== 0) begin
            errors++;
            $display("FAIL pad_stream: got %0d bad dibits, expected 0", stream_errs(exp_q.size() * 4));
        end
        r = 32'hFFFF_FFFF;
        for (int j = 8; j < cap.size() / 4; j++) begin
            b = {cap[4*j+3], cap[4*j+2], cap[4*j+1], cap[4*j]};
            r = crc_upd(r, b);
        end
        checks++;
        if (r !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL pad_crc_residue: got %h, expected debb20e3", r);
        end
    endtask

    task automatic test_dibit_order();
        logic [1:0] want[8];
        int bad;
        want = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
        load_fifo(1, 1'b0);
        src[0]  = 8'hA5;
        fifo[0] = 8'hA5;
        start_frame(1);
        run_frame(3000);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (cap.size() <= 28 + k) bad++;
            else if (cap[28+k] !== want[k]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL dibit_order: got %0d wrong dibits around SFD, expected 0", bad);
        end
    endtask

    task automatic test_underrun();
        load_fifo(20, 1'b0);
        start_frame(100);
        run_frame(3000);
        build_exp(20);
        checks++;
        if (n_rd !== 20) begin errors++; $display("FAIL und_rd_count: got %0d, expected 20", n_rd); end
        checks++;
        if (n_und !== 1 || und_cyc !== fall_cyc || fall_cyc !== 111) begin
            errors++;
            $display("FAIL und_pulse: got %0d pulses at %0d, tx_en fell at %0d, expected 1 at 111",
                     n_und, und_cyc, fall_cyc);
        end
        checks++;
        if (busy_low_cyc - fall_cyc !== IFG_CYCLES || n_done !== 0) begin
            errors++;
            $display("FAIL und_gap: got busy low +%0d done=%0d, expected +%0d done=0",
                     busy_low_cyc - fall_cyc, n_done, IFG_CYCLES);
        end
        checks++;
        if (stream_errs(111) !== 0 || cap.size() !== 111) begin
            errors++;
            $display("FAIL und_stream: got %0d bad of %0d, expected 0 of 111",
                     stream_errs(111), cap.size());
        end
    endtask

    task automatic test_reset_mid();
        load_fifo(100, 1'b0);
        start_frame(100);
        repeat (154) @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if ({Rd_En, Tx_En, Txd, Busy, Done, Underrun} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 0000000",
                     {Rd_En, Tx_En, Txd, Busy, Done, Underrun});
        end
        Rst = 1'b0;
        load_fifo(30, 1'b0);
        start_frame(30);
        run_frame(3000);
        build_exp(30);
        checks++;
        if (stream_errs(exp_q.size() * 4) !== 0 || n_done !== 1 || n_rd !== 30) begin
            errors++;
            $display("FAIL midreset_next_frame: got %0d bad dibits done=%0d rd=%0d, expected 0 1 30",
                     stream_errs(exp_q.size() * 4), n_done, n_rd);
        end
    endtask

    task automatic test_ignore_start();
        int busy_hi;
        load_fifo(70, 1'b1);
        start_frame(60);
        fork
            run_frame(3000);
            begin
                repeat (100) @(posedge Clk);
                #1 Tx_Start = 1'b1; Byte_Count = 11'd7;
                @(posedge Clk);
                #1 Tx_Start = 1'b0;
                repeat (199) @(posedge Clk);
                #1 Tx_Start = 1'b1; Byte_Count = 11'd9;
                @(posedge Clk);
                #1 Tx_Start = 1'b0;
            end
        join
        build_exp(60);
        checks++;
        if (stream_errs(exp_q.size() * 4) !== 0 || n_rd !== 60 || n_done !== 1) begin
            errors++;
            $display("FAIL ignore_single_frame: got %0d bad dibits rd=%0d done=%0d, expected 0 60 1",
                     stream_errs(exp_q.size() * 4), n_rd, n_done);
        end
        busy_hi = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Busy !== 1'b0) busy_hi++;
        end
        checks++;
        if (busy_hi !== 0) begin
            errors++;
            $display("FAIL ignore_no_restart: got %0d busy cycles, expected 0", busy_hi);
        end
    endtask

    task automatic test_zero_count();
        int busy_hi;
        load_fifo(5, 1'b0);
        @(posedge Clk);
        #1 Tx_Start = 1'b1; Byte_Count = 11'd0;
        @(posedge Clk);
        #1 Tx_Start = 1'b0;
        busy_hi = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Busy !== 1'b0 || Rd_En !== 1'b0) busy_hi++;
        end
        checks++;
        if (busy_hi !== 0) begin
            errors++;
            $display("FAIL zero_count: got %0d active cycles, expected 0", busy_hi);
        end
    endtask

    task automatic test_random();
        int len, padded;
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(1, 100);
            load_fifo(len + $urandom_range(0, 3), 1'b0);
            start_frame(len);
            run_frame(3000);
            build_exp(len);
            padded = (len < MIN_BYTES) ? MIN_BYTES : len;
            checks++;
            if (stream_errs(exp_q.size() * 4) !== 0 || cap.size() !== exp_q.size() * 4) begin
                errors++;
                $display("FAIL random_stream len=%0d: got %0d bad of %0d, expected 0 of %0d",
                         len, stream_errs(exp_q.size() * 4), cap.size(), exp_q.size() * 4);
            end
            checks++;
            if (n_rd !== len || ten_cyc !== 4 * (12 + padded)) begin
                errors++;
                $display("FAIL random_counts len=%0d: got rd=%0d tx_en=%0d, expected %0d %0d",
                         len, n_rd, ten_cyc, len, 4 * (12 + padded));
            end
            checks++;
            if (n_done !== 1 || done_cyc - fall_cyc !== IFG_CYCLES) begin
                errors++;
                $display("FAIL random_done len=%0d: got %0d at +%0d, expected 1 at +%0d",
                         len, n_done, done_cyc - fall_cyc, IFG_CYCLES);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_60();
        test_pad_14();
        test_dibit_order();
        test_underrun();
        test_reset_mid();
        test_ignore_start();
        test_zero_count();
        test_random();
        checks++;
        if (bad_pops !== 0) begin
            errors++;
            $display("FAIL pop_guard: got %0d illegal pops, expected 0", bad_pops);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
